dmem_arb: RTL

DMEM_ARB -- requirements
Module: dmem_arb

---
 rtl/dmem_arb_if.sv | 42 ++++
 rtl/dmem_arb.sv | 98 +++++++++
 2 files changed

// File: rtl/dmem_arb_if.sv
// Bundle of the load-queue, store-queue and cache-port signals around dmem_arb.
// slave is the arbiter's view; master is the requesters' and cache's view.
interface dmem_arb_if;
   logic        ldq_valid;
   logic        ldq_ready;
   logic [31:0] ldq_addr;
   logic [3:0]  ldq_rmask;
   logic        ldq_resp;
   logic [31:0] ldq_rdata;

   logic        stq_valid;
   logic        stq_ready;
   logic [31:0] stq_addr;
   logic [3:0]  stq_wmask;
   logic [31:0] stq_wdata;
   logic        stq_resp;

   logic [31:0] dmem_addr;
   logic [3:0]  dmem_rmask;
   logic [3:0]  dmem_wmask;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_resp;

   modport slave (
      input  ldq_valid, ldq_addr, ldq_rmask,
      input  stq_valid, stq_addr, stq_wmask, stq_wdata,
      input  dmem_rdata, dmem_resp,
      output ldq_ready, ldq_resp, ldq_rdata,
      output stq_ready, stq_resp,
      output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata
   );

   modport master (
      output ldq_valid, ldq_addr, ldq_rmask,
      output stq_valid, stq_addr, stq_wmask, stq_wdata,
      output dmem_rdata, dmem_resp,
      input  ldq_ready, ldq_resp, ldq_rdata,
      input  stq_ready, stq_resp,
      input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata
   );
endinterface

// File: rtl/dmem_arb.sv
// Load/store queue arbiter onto a single data-cache port, one request in flight.
// Define DMEM_ARB_RR_EN for round-robin grants instead of load priority with starvation guard.
module dmem_arb #(
   parameter int unsigned STARVE_LIMIT = 8
) (
   input logic       clk,
   input logic       rst_n,
   dmem_arb_if.slave bus
);

   typedef enum logic [1:0] {IDLE, LD_BUSY, ST_BUSY} state_t;

   state_t      state;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  rmask_q;
   logic [3:0]  wmask_q;
   logic        ld_win;
   logic        ld_acc;
   logic        st_acc;

`ifdef DMEM_ARB_RR_EN
   logic rr_last;  // 1: store was granted last

   always_comb begin
      ld_win = bus.ldq_valid && (!bus.stq_valid || rr_last);
   end
`else
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
   logic [3:0] starve_cnt;

   always_comb begin
      ld_win = bus.ldq_valid && !(bus.stq_valid && (starve_cnt == LIMIT));
   end
`endif

   // Ready is masked by rst_n so every output reads 0 while reset is held.
   always_comb begin
      bus.ldq_ready  = rst_n && (state == IDLE) && ld_win;
      bus.stq_ready  = rst_n && (state == IDLE) && bus.stq_valid && !ld_win;
      ld_acc         = bus.ldq_valid && bus.ldq_ready;
      st_acc         = bus.stq_valid && bus.stq_ready;
      bus.ldq_resp   = (state == LD_BUSY) && bus.dmem_resp;
      bus.stq_resp   = (state == ST_BUSY) && bus.dmem_resp;
      bus.ldq_rdata  = bus.ldq_resp ? bus.dmem_rdata : '0;
      bus.dmem_addr  = addr_q;
      bus.dmem_wdata = wdata_q;
      bus.dmem_rmask = (state == LD_BUSY) ? rmask_q : '0;
      bus.dmem_wmask = (state == ST_BUSY) ? wmask_q : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         rmask_q <= '0;
         wmask_q <= '0;
`ifdef DMEM_ARB_RR_EN
         rr_last <= 1'b1;
`else
         starve_cnt <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (ld_acc) begin
                  addr_q  <= bus.ldq_addr;
                  rmask_q <= bus.ldq_rmask;
                  state   <= LD_BUSY;
               end else if (st_acc) begin
                  addr_q  <= bus.stq_addr;
                  wmask_q <= bus.stq_wmask;
                  wdata_q <= bus.stq_wdata;
                  state   <= ST_BUSY;
               end
`ifdef DMEM_ARB_RR_EN
               if (ld_acc)
                  rr_last <= 1'b0;
               else if (st_acc)
                  rr_last <= 1'b1;
`else
               if (!bus.stq_valid || st_acc)
                  starve_cnt <= '0;
               else if (ld_acc && (starve_cnt != LIMIT))
                  starve_cnt <= starve_cnt + 4'd1;
`endif
            end
            LD_BUSY, ST_BUSY: begin
               if (bus.dmem_resp)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
